// File: rtl/shreg_pkg.sv
// Shared types for the shift-register sequencer: command opcodes,
// sequencer FSM states and the per-cycle datapath control codes.
package shreg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SHL   = 2'b01,
    OP_SHR   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    DP_HOLD = 3'd0,
    DP_LOAD = 3'd1,
    DP_SHL  = 3'd2,
    DP_SHR  = 3'd3,
    DP_CLR  = 3'd4,
    DP_ROTL = 3'd5,
    DP_ROTR = 3'd6
  } dp_t;

endpackage

// File: rtl/shreg_core.sv
// WIDTH-bit universal shift register driven by a one-hot-free DP_* code.
// Exposes both the registered value and the value it will take at the
// next edge so the sequencer can capture the final result in the same
// cycle the register is written.
// Optional feature macro: ROTATE_EN (adds rotate-left/right operations).
module shreg_core
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  dp_t              dp,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
);

  // Next-value selection for the register; anything unrecognised holds.
  always_comb begin
    q_next = q;
    case (dp)
      DP_LOAD: q_next = load_data;
      DP_CLR:  q_next = '0;
      DP_SHL:  q_next = {q[WIDTH-2:0], ser_in};
      DP_SHR:  q_next = {ser_in, q[WIDTH-1:1]};
`ifdef ROTATE_EN
      DP_ROTL: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      DP_ROTR: q_next = {q[0], q[WIDTH-1:1]};
`endif
      default: q_next = q;
    endcase
  end

  // Storage element; the async clear also aborts any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= q_next;
  end

endmodule

// File: rtl/shreg_sequencer.sv
// Command-driven sequencer around shreg_core. Accepts one command in IDLE,
// steps the register once per clock in EXEC, then presents the final value
// in RESP until the host takes it.
// Optional feature macro: ROTATE_EN (cmd_rot selects rotate for SHL/SHR).
module shreg_sequencer
  import shreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             cmd_rot,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] q
);

  state_t           state;
  op_t              op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] data_r;
  dp_t              dp;
  logic [WIDTH-1:0] q_next;
  logic             accept;
  logic             exec_done;
  logic             is_shift;

`ifdef ROTATE_EN
  logic rot_r;
`else
  logic unused_rot;
  assign unused_rot = cmd_rot;
`endif

  assign cmd_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state == ST_EXEC) || (state == ST_RESP);
  assign accept    = cmd_valid && cmd_ready;

  // LOAD/CLEAR and zero-count shifts finish after a single EXEC cycle;
  // shifts leave EXEC when the remaining-step counter reaches one.
  always_comb begin
    is_shift  = (op_r == OP_SHL) || (op_r == OP_SHR);
    exec_done = !is_shift || (cnt_r <= CNT_W'(1));
  end

  // Translate the latched command into this cycle's datapath operation.
  always_comb begin
    dp = DP_HOLD;
    if (state == ST_EXEC) begin
      case (op_r)
        OP_LOAD:  dp = DP_LOAD;
        OP_CLEAR: dp = DP_CLR;
        OP_SHL: begin
          if (cnt_r != '0) begin
`ifdef ROTATE_EN
            dp = rot_r ? DP_ROTL : DP_SHL;
`else
            dp = DP_SHL;
`endif
          end
        end
        OP_SHR: begin
          if (cnt_r != '0) begin
`ifdef ROTATE_EN
            dp = rot_r ? DP_ROTR : DP_SHR;
`else
            dp = DP_SHR;
`endif
          end
        end
        default: dp = DP_HOLD;
      endcase
    end
  end

  // FSM, command latches, step counter and the held response value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op_r     <= OP_LOAD;
      cnt_r    <= '0;
      data_r   <= '0;
      rsp_data <= '0;
`ifdef ROTATE_EN
      rot_r    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_r   <= op_t'(cmd_op);
            cnt_r  <= cmd_cnt;
            data_r <= cmd_data;
`ifdef ROTATE_EN
            rot_r  <= cmd_rot;
`endif
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            rsp_data <= q_next;
            state    <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  shreg_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .dp        (dp),
    .ser_in    (ser_in),
    .load_data (data_r),
    .q         (q),
    .q_next    (q_next)
  );

endmodule

// File: tb/tb_shreg_sequencer.sv
// Self-checking bench for shreg_sequencer (WIDTH=4, CNT_W=3). Expected
// responses are computed by a small reference model, pushed to a queue at
// command issue and popped when the DUT raises rsp_valid.
// Optional feature macro: ROTATE_EN (enables the rotate scenario).
module tb_shreg_sequencer;

`ifdef ROTATE_EN
  localparam bit ROT_BUILD = 1'b1;
`else
  localparam bit ROT_BUILD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic       cmd_rot;
  logic [3:0] cmd_data;
  logic       ser_in;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       busy;
  logic [3:0] q;

  int         errors = 0;
  int         checks = 0;
  logic [3:0] model_q = 4'b0000;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  shreg_sequencer #(
    .WIDTH(4),
    .CNT_W(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_rot   (cmd_rot),
    .cmd_data  (cmd_data),
    .ser_in    (ser_in),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .q         (q)
  );

  // One register step of the reference model.
  function automatic logic [3:0] model_step(input logic [3:0] cur, input logic [1:0] op,
                                            input logic sbit, input logic rot);
    if (rot && ROT_BUILD) begin
      if (op == 2'b01) return {cur[2:0], cur[3]};
      return {cur[0], cur[3:1]};
    end
    if (op == 2'b01) return {cur[2:0], sbit};
    if (op == 2'b10) return {sbit, cur[3:1]};
    return cur;
  endfunction

  // Whole-command result of the reference model.
  function automatic logic [3:0] model_cmd(input logic [3:0] cur, input logic [1:0] op,
                                           input logic [2:0] cnt, input logic [3:0] data,
                                           input logic [7:0] ser, input logic rot);
    logic [3:0] m;
    if (op == 2'b00) return data;
    if (op == 2'b11) return 4'b0000;
    m = cur;
    for (int i = 0; i < int'(cnt); i++) m = model_step(m, op, ser[i], rot);
    return m;
  endfunction

  // Issue one command at a negedge in IDLE, follow it step by step, pop
  // and compare the response, optionally stall rsp_ready and pulse a
  // stray command during the stall, then complete the handshake.
  task automatic run_cmd(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic [7:0] ser, input logic rot, input int hold,
                         input logic pulse, input string name);
    logic [3:0] mq;
    logic [3:0] final_q;
    logic [3:0] exp;
    logic       shift;
    int         lat;
    shift   = (op == 2'b01) || (op == 2'b10);
    final_q = model_cmd(model_q, op, cnt, data, ser, rot);
    lat     = (shift && cnt != 3'd0) ? int'(cnt) : 1;
    exp_q.push_back(final_q);

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s cmd_ready_idle: got %b want 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_rot   = rot;
    ser_in    = ser[0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom_range(0, 3));
    cmd_cnt   = 3'($urandom_range(0, 7));
    cmd_data  = ~data;
    cmd_rot   = ~rot;

    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || q !== model_q) begin
      errors++;
      $display("[TB] FAIL %s after_accept: busy=%b rsp_valid=%b q=%b want busy=1 rsp_valid=0 q=%b",
               name, busy, rsp_valid, q, model_q);
    end

    mq = model_q;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      if (shift) begin
        if (j <= int'(cnt)) mq = model_step(mq, op, ser[j-1], rot);
      end else begin
        mq = final_q;
      end
      ser_in = ser[j];
      checks++;
      if (q !== mq || rsp_valid !== (j == lat) || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s step%0d: q=%b rsp_valid=%b busy=%b want q=%b rsp_valid=%b busy=1",
                 name, j, q, rsp_valid, busy, mq, (j == lat));
      end
    end

    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s scoreboard_empty: got 0 entries want 1", name);
      exp = 4'bxxxx;
    end else begin
      exp = exp_q.pop_front();
      if (rsp_data !== exp) begin
        errors++;
        $display("[TB] FAIL %s rsp_data: got %b want %b", name, rsp_data, exp);
      end
    end
    model_q = final_q;

    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      if (pulse && h == 1) begin
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_data  = ~final_q;
      end
      if (pulse && h == 2) cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || cmd_ready !== 1'b0 || q !== final_q) begin
        errors++;
        $display("[TB] FAIL %s stall%0d: rsp_valid=%b rsp_data=%b cmd_ready=%b q=%b want 1 %b 0 %b",
                 name, h, rsp_valid, rsp_data, cmd_ready, q, exp, final_q);
      end
    end
    cmd_valid = 1'b0;

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || q !== final_q) begin
      errors++;
      $display("[TB] FAIL %s release: rsp_valid=%b busy=%b cmd_ready=%b q=%b want 0 0 1 %b",
               name, rsp_valid, busy, cmd_ready, q, final_q);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_cnt   = 3'd0;
    cmd_rot   = 1'b0;
    cmd_data  = 4'b0000;
    ser_in    = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_state: q=%b rsp_valid=%b busy=%b rsp_data=%b want 0000 0 0 0000",
               q, rsp_valid, busy, rsp_data);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
    model_q = 4'b0000;
  endtask

  task automatic test_load;
    run_cmd(2'b00, 3'd5, 4'b1011, 8'h00, 1'b0, 0, 1'b0, "load");
  endtask

  task automatic test_shift;
    run_cmd(2'b01, 3'd2, 4'b0000, 8'h00, 1'b0, 0, 1'b0, "shl2");
    run_cmd(2'b00, 3'd0, 4'b1011, 8'h00, 1'b0, 0, 1'b0, "reload1");
    run_cmd(2'b10, 3'd3, 4'b0000, 8'hFF, 1'b0, 0, 1'b0, "shr3");
    run_cmd(2'b00, 3'd0, 4'b1011, 8'h00, 1'b0, 0, 1'b0, "reload2");
    run_cmd(2'b01, 3'd0, 4'b0000, 8'hFF, 1'b0, 1, 1'b0, "shl0");
    run_cmd(2'b10, 3'd7, 4'b0000, 8'b0101_1010, 1'b0, 0, 1'b0, "shr7_var");
    run_cmd(2'b01, 3'd5, 4'b0000, 8'b0011_0110, 1'b0, 0, 1'b0, "shl5_var");
    run_cmd(2'b11, 3'd4, 4'b1111, 8'hFF, 1'b0, 0, 1'b0, "clear");
  endtask

  task automatic test_stall;
    run_cmd(2'b00, 3'd0, 4'b0110, 8'h00, 1'b0, 5, 1'b1, "stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || q !== model_q) begin
        errors++;
        $display("[TB] FAIL stall_ignored%0d: rsp_valid=%b busy=%b q=%b want 0 0 %b",
                 i, rsp_valid, busy, q, model_q);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_cmd(2'b00, 3'd0, 4'b1001, 8'h00, 1'b0, 0, 1'b0, "b2b_load");
    run_cmd(2'b10, 3'd1, 4'b0000, 8'h01, 1'b0, 0, 1'b0, "b2b_shr1");
    run_cmd(2'b01, 3'd4, 4'b0000, 8'h05, 1'b0, 0, 1'b0, "b2b_shl4");
    run_cmd(2'b11, 3'd0, 4'b0000, 8'h00, 1'b0, 0, 1'b0, "b2b_clear");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), $urandom_range(0, 2),
              1'b0, "random");
    end
  endtask

  task automatic test_reset_abort;
    run_cmd(2'b00, 3'd0, 4'b0101, 8'h00, 1'b0, 0, 1'b0, "abort_preload");
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_cnt   = 3'd7;
    cmd_data  = 4'b0000;
    cmd_rot   = 1'b0;
    ser_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (q !== 4'b0000 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_reset: q=%b rsp_valid=%b busy=%b want 0000 0 0", q, rsp_valid, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    model_q = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || q !== 4'b0000 || cmd_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL abort_after%0d: rsp_valid=%b q=%b cmd_ready=%b want 0 0000 1",
                 i, rsp_valid, q, cmd_ready);
      end
    end
  endtask

`ifdef ROTATE_EN
  task automatic test_rotate;
    run_cmd(2'b00, 3'd0, 4'b1011, 8'h00, 1'b0, 0, 1'b0, "rot_load1");
    run_cmd(2'b01, 3'd1, 4'b0000, 8'h00, 1'b1, 0, 1'b0, "rotl1");
    run_cmd(2'b00, 3'd0, 4'b1011, 8'h00, 1'b0, 0, 1'b0, "rot_load2");
    run_cmd(2'b10, 3'd1, 4'b0000, 8'h00, 1'b1, 0, 1'b0, "rotr1");
    run_cmd(2'b01, 3'd6, 4'b0000, 8'hFF, 1'b1, 0, 1'b0, "rotl6");
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_abort();
`ifdef ROTATE_EN
    test_rotate();
`endif
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
